// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider, signed or unsigned.
// One quotient bit per clock; fixed latency of WIDTH+1 edges from start to done.
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;       // raw dividend, returned as remainder on divide-by-zero
  logic [WIDTH-1:0] dmag_q;    // divisor magnitude
  logic [WIDTH-1:0] rem_q;     // partial remainder
  logic [WIDTH-1:0] quo_q;     // dividend shifts out of the top while quotient shifts in
  logic [CW-1:0]    cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic             bz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_d;

  // Operand magnitudes for the incoming request
  always_comb begin
    a_neg = sign & a[WIDTH-1];
    b_neg = sign & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One restoring step: shift, trial subtract, keep or restore
  always_comb begin
    shl  = {rem_q, quo_q[WIDTH-1]};
    diff = shl - {1'b0, dmag_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shl[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and divide-by-zero substitution for the final result
  always_comb begin
    if (bz_q) begin
      q_d = '1;
      r_d = a_q;
    end else begin
      q_d = negq_q ? (~quo_q + 1'b1) : quo_q;
      r_d = negr_q ? (~rem_q + 1'b1) : rem_q;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      dmag_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            dmag_q  <= b_mag;
            quo_q   <= a_mag;
            rem_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            negq_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
            bz_q    <= (b == '0);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          q_q     <= q_d;
          r_q     <= r_d;
          dbz_q   <= bz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; all state clears while low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sign  input  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start.
REQ-006 a  input  WIDTH  dividend; sampled with start.
REQ-007 b  input  WIDTH  divisor; sampled with start.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  single-cycle pulse; q, r and dbz are valid.
REQ-010 q  output  WIDTH  quotient, registered.
REQ-011 r  output  WIDTH  remainder, registered.
REQ-012 dbz  output  1  divide-by-zero flag for the last result, registered.

Function
REQ-013 States: IDLE, CALC, FIX; IDLE is the reset state.
REQ-014 IDLE with start=1 at edge N: latch a, b and sign; compute magnitudes (negate negative operands when sign=1); clear partial remainder; load step counter with WIDTH; enter CALC.
REQ-015 CALC: one radix-2 restoring step per edge: shift {rem,quo} left 1, subtract |b| from rem, keep the difference and set the quotient LSB to 1 if it is non-negative, otherwise restore rem and set the LSB to 0; decrement counter; after WIDTH steps (edge N+WIDTH) enter FIX.
REQ-016 FIX (edge N+WIDTH+1): apply sign correction, register q, r and dbz, pulse done, return to IDLE.
REQ-017 Latency: done=1 in the cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32); fixed and data-independent, including when b=0.
REQ-018 busy=1 from the cycle after edge N until FIX completes; busy=0 in the cycle where done=1.
REQ-019 done is high for exactly one cycle per accepted start.
REQ-020 start while busy=1 is ignored; operands are not re-sampled.
REQ-021 start=1 in the same cycle as done=1 is accepted (back-to-back); the next done follows WIDTH+1 edges later.
REQ-022 Signed sign rules: quotient negative iff a and b signs differ; remainder takes the sign of a; |r| < |b|; a = q*b + r.
REQ-023 Signed overflow: a=0x80000000, b=0xFFFFFFFF gives q=0x80000000, r=0, dbz=0.
REQ-024 b=0: dbz=1, q=all ones, r=a (unmodified, both modes); otherwise dbz=0.
REQ-025 q, r and dbz hold their values until the next FIX; they do not change during CALC.

Reset
REQ-026 reset low sets the following asynchronously: state=IDLE, busy=0, done=0, q=0, r=0, dbz=0, counter=0, internal datapath registers=0.
REQ-027 reset asserted mid-operation aborts the division; no done is issued for it; the first start after reset release starts a fresh operation.

Verification
REQ-028 Unsigned: sign=0, a=100, b=7 -> done exactly 33 cycles after start; q=14, r=2, dbz=0.
REQ-029 Signed: sign=1, a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); sign=0 with the same operands -> q=0x7FFFFFFC, r=1.
REQ-030 Divide by zero: a=0x12345678, b=0, sign=1 -> dbz=1, q=0xFFFFFFFF, r=0x12345678, latency 33 cycles.
REQ-031 Overflow plus back-to-back: signed 0x80000000 / 0xFFFFFFFF, with start re-asserted in the cycle done=1 for 0xFFFFFFFF / 0x10 unsigned -> first result q=0x80000000, r=0; second done 33 cycles later with q=0x0FFFFFFF, r=0xF.
REQ-032 Start while busy: a second start with different operands 5 cycles into an operation -> ignored; exactly one done with the first operation's result.
REQ-033 Reset mid-operation: reset low at cycle 10 of CALC -> busy=0, q=0, r=0 immediately; no done; a new 9/3 unsigned start after release -> q=3, r=0.
